// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage core: converts hazard, MULT/DIV and taken-branch
// events into stage enables and flush controls. Optional macro: PIPELINE_SEQUENCER_PERF_CNT_EN.
module pipeline_sequencer #(
  parameter int unsigned MD_CYCLES   = 8,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        haz_stall,
  input  logic        md_start,
  input  logic        br_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [1:0]  seq_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STALL   = 2'd1,
    S_MD_WAIT = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam logic [7:0] MD_LOAD    = 8'(MD_CYCLES - 1);
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_DEPTH - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pc_en_q, if_id_en_q, id_ex_en_q;
  logic       if_id_flush_q, id_ex_flush_q, md_busy_q, md_done_q;

  // Next state and shared down-counter; requests are only honoured from RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (br_taken) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (md_start) begin
          state_d = S_MD_WAIT;
          cnt_d   = MD_LOAD;
        end else if (haz_stall) begin
          state_d = S_STALL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STALL: state_d = S_RUN;
      S_MD_WAIT, S_FLUSH: begin
        if (cnt_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State register plus outputs pre-decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      cnt_q         <= 8'd0;
      pc_en_q       <= 1'b1;
      if_id_en_q    <= 1'b1;
      id_ex_en_q    <= 1'b1;
      if_id_flush_q <= 1'b0;
      id_ex_flush_q <= 1'b0;
      md_busy_q     <= 1'b0;
      md_done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= (state_d == S_MD_WAIT) && (cnt_d == 8'd0);
      case (state_d)
        S_RUN: begin
          {pc_en_q, if_id_en_q, id_ex_en_q} <= 3'b111;
          {if_id_flush_q, id_ex_flush_q, md_busy_q} <= 3'b000;
        end
        S_STALL: begin
          {pc_en_q, if_id_en_q, id_ex_en_q} <= 3'b001;
          {if_id_flush_q, id_ex_flush_q, md_busy_q} <= 3'b010;
        end
        S_MD_WAIT: begin
          {pc_en_q, if_id_en_q, id_ex_en_q} <= 3'b000;
          {if_id_flush_q, id_ex_flush_q, md_busy_q} <= 3'b001;
        end
        S_FLUSH: begin
          {pc_en_q, if_id_en_q, id_ex_en_q} <= 3'b111;
          {if_id_flush_q, id_ex_flush_q, md_busy_q} <= 3'b110;
        end
        default: begin
          {pc_en_q, if_id_en_q, id_ex_en_q} <= 3'b111;
          {if_id_flush_q, id_ex_flush_q, md_busy_q} <= 3'b000;
        end
      endcase
    end
  end

  assign pc_en       = pc_en_q;
  assign if_id_en    = if_id_en_q;
  assign id_ex_en    = id_ex_en_q;
  assign if_id_flush = if_id_flush_q;
  assign id_ex_flush = id_ex_flush_q;
  assign md_busy     = md_busy_q;
  assign md_done     = md_done_q;
  assign seq_state   = state_q;

`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of every cycle spent outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q != S_RUN) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed table, corner sequences, random
// stimulus against a cycle-plan reference model, and a long-run counter saturation check.
module tb_pipeline_sequencer;

  localparam int MDC = 8;
  localparam int FD  = 2;
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic haz = 1'b0, mds = 1'b0, brt = 1'b0;
  logic md_hold = 1'b1, zero_in = 1'b0;
  logic pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, md_busy, md_done;
  logic [1:0]  seq_state;
  logic [15:0] stall_cycles;
  logic p2_pc, p2_ifid, p2_idex, p2_iff, p2_idf, p2_busy, p2_done;
  logic [1:0]  p2_state;
  logic [15:0] p2_stall;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipeline_sequencer #(.MD_CYCLES(MDC), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .haz_stall(haz), .md_start(mds), .br_taken(brt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_busy(md_busy), .md_done(md_done),
    .seq_state(seq_state), .stall_cycles(stall_cycles));

  pipeline_sequencer #(.MD_CYCLES(255), .FLUSH_DEPTH(7)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .haz_stall(zero_in), .md_start(md_hold), .br_taken(zero_in),
    .pc_en(p2_pc), .if_id_en(p2_ifid), .id_ex_en(p2_idex), .if_id_flush(p2_iff),
    .id_ex_flush(p2_idf), .md_busy(p2_busy), .md_done(p2_done),
    .seq_state(p2_state), .stall_cycles(p2_stall));

  typedef struct packed { logic [1:0] st; logic done; } step_t;
  typedef struct { logic h, m, b; logic [1:0] st; int len; } vec_t;

  step_t       cur;
  step_t       pend[$];
  logic [15:0] perf;
  int n_cmp = 0, n_err = 0;
  vec_t tbl[6];

  // Expected {pc_en,if_id_en,id_ex_en,if_id_flush,id_ex_flush,md_busy,md_done} per state.
  function automatic logic [6:0] exp_out(input logic [1:0] st, input logic done);
    case (st)
      2'd0:    return 7'b1110000;
      2'd1:    return 7'b0010100;
      2'd2:    return {6'b000001, done};
      default: return 7'b1111100;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cur  = '{st: 2'd0, done: 1'b0};
    perf = 16'h0000;
  endtask

  task automatic compare_all();
    chk("outs", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, md_busy, md_done},
        exp_out(cur.st, cur.done));
    chk("state", seq_state, cur.st);
    chk("stall_cycles", stall_cycles, perf);
  endtask

  // One clock: drive inputs, let the DUT take the edge, advance the plan, compare at negedge.
  task automatic cycle(input logic h, input logic m, input logic b);
    haz = h; mds = m; brt = b;
    @(posedge clk);
    if (cur.st == 2'd0) begin
      if (b) begin
        for (int i = 0; i < FD; i++) pend.push_back('{st: 2'd3, done: 1'b0});
      end else if (m) begin
        for (int i = 0; i < MDC; i++) pend.push_back('{st: 2'd2, done: (i == MDC - 1)});
      end else if (h) begin
        pend.push_back('{st: 2'd1, done: 1'b0});
      end
    end
    if (PERF && cur.st != 2'd0 && perf != 16'hFFFF) perf = perf + 16'h0001;
    cur = (pend.size() != 0) ? pend.pop_front() : '{st: 2'd0, done: 1'b0};
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    tbl[0] = '{h: 1'b1, m: 1'b0, b: 1'b0, st: 2'd1, len: 1};
    tbl[1] = '{h: 1'b0, m: 1'b1, b: 1'b0, st: 2'd2, len: MDC};
    tbl[2] = '{h: 1'b0, m: 1'b0, b: 1'b1, st: 2'd3, len: FD};
    tbl[3] = '{h: 1'b1, m: 1'b1, b: 1'b1, st: 2'd3, len: FD};
    tbl[4] = '{h: 1'b1, m: 1'b1, b: 1'b0, st: 2'd2, len: MDC};
    tbl[5] = '{h: 1'b1, m: 1'b0, b: 1'b1, st: 2'd3, len: FD};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1; rst2_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);

    // Directed table: one-cycle request from RUN, then fixed-length sequence, then RUN.
    for (int t = 0; t < 6; t++) begin
      cycle(tbl[t].h, tbl[t].m, tbl[t].b);
      for (int k = 0; k < tbl[t].len; k++) begin
        chk("tbl_state", seq_state, tbl[t].st);
        chk("tbl_done", md_done, (tbl[t].st == 2'd2) && (k == tbl[t].len - 1));
        chk("tbl_busy", md_busy, tbl[t].st == 2'd2);
        cycle(1'b0, 1'b0, 1'b0);
      end
      chk("tbl_back_to_run", seq_state, 2'd0);
      if (t == 0) chk("stall_after_haz", stall_cycles, PERF ? 32'd1 : 32'd0);
    end

    // Back-to-back: new request accepted in the first RUN cycle after return.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("b2b_run_gap", seq_state, 2'd0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("b2b_md_accepted", md_busy, 1'b1);
    for (int i = 0; i < MDC; i++) cycle(1'b0, 1'b0, 1'b0);

    // Reset in the 4th MD_WAIT cycle aborts the sequence without md_done.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_md_wait", seq_state, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, md_busy, md_done},
        7'b1110000);
    chk("async_rst_state", seq_state, 2'd0);
    chk("async_rst_perf", stall_cycles, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MDC; i++) cycle(1'b0, 1'b0, 1'b0);

    // Random stimulus against the plan model.
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);

    // Long-run counter on the MD_CYCLES=255 instance with md_start held high.
    if (PERF) begin
      while (cyc < 66300) @(posedge clk);
      @(negedge clk);
      chk("sat_reached", p2_stall, 32'h0000FFFF);
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("sat_no_wrap", p2_stall, 32'h0000FFFF);
    end else begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("perf_tied_zero", p2_stall, 32'd0);
    end
    chk("sat_inst_busy", {p2_busy, p2_state} != 3'b000 || p2_state == 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Pipeline stall/flush sequencer for the 5-stage core. It turns hazard-unit stall requests, taken-branch resolution and multi-cycle MULT/DIV issue into per-stage register enables and bubble/flush controls. It sits beside the control hazard unit: that unit decides *when* a hazard exists, this block decides *how many cycles* the front end freezes or is squashed.

## Interface
Parameters:
- MD_CYCLES, default 8: total EX occupancy of a MULT/DIV, in cycles; legal range 1..255.
- FLUSH_DEPTH, default 2: number of squash cycles after a taken branch; legal range 1..7.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  reset. Asynchronous assertion, active-low (decided).
- haz_stall  in  1  load-to-branch stall request from the control hazard unit.
- md_start  in  1  MULT/DIV entering EX this cycle (s2_R0_en qualified by opcode).
- br_taken  in  1  branch in EX resolved taken this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID pipeline register enable.
- id_ex_en  out  1  ID/EX pipeline register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP (bubble) into ID/EX.
- md_busy  out  1  MULT/DIV occupying EX.
- md_done  out  1  one-cycle pulse on the last MULT/DIV cycle.
- seq_state  out  2  current state: RUN=0, STALL=1, MD_WAIT=2, FLUSH=3.
- stall_cycles  out  16  saturating count of non-RUN cycles (see Configuration).

## Operation
- FSM states: RUN, STALL, MD_WAIT, FLUSH. A single down-counter `cnt` (8 bits) is shared by MD_WAIT and FLUSH.
- Inputs are sampled only in RUN. They are ignored in every other state.
- RUN transitions, in priority order:
  - br_taken goes to FLUSH with cnt=FLUSH_DEPTH-1.
  - Otherwise md_start goes to MD_WAIT with cnt=MD_CYCLES-1. If MD_CYCLES=1, go to MD_WAIT with cnt=0.
  - Otherwise haz_stall goes to STALL.
  - Otherwise stay in RUN.
- STALL lasts exactly one cycle, then returns to RUN.
- MD_WAIT: when cnt==0, md_done=1 and the next state is RUN; otherwise cnt decrements.
- FLUSH: when cnt==0, the next state is RUN; otherwise cnt decrements.
- Outputs are Moore, decoded from state only, with these values:
  - RUN: pc_en=1, if_id_en=1, id_ex_en=1, flushes=0, md_busy=0.
  - STALL: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1.
  - MD_WAIT: pc_en=0, if_id_en=0, id_ex_en=0, flushes=0, md_busy=1.
  - FLUSH: pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1.
- md_done is the only output that also depends on cnt: it is 1 only when state is MD_WAIT and cnt==0.
- Simultaneous br_taken and md_start: the branch wins. The MULT/DIV is wrong-path and is squashed by FLUSH; md_busy never asserts.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, cnt=0, stall_cycles=0. Outputs immediately show the RUN values, with md_done=0.
- Reset asserted mid-MD_WAIT or mid-FLUSH aborts the sequence immediately; there is no md_done pulse.
- Request sampled at edge N: the new state's outputs are valid after edge N, i.e. in cycle N+1.
- Cycles spent per request:
  - STALL: 1 cycle.
  - MD_WAIT: MD_CYCLES cycles.
  - FLUSH: FLUSH_DEPTH cycles.
- Back-to-back requests are accepted in the first RUN cycle after return. The minimum RUN gap is one cycle.
- md_done pulses exactly once per MD_WAIT, in its final cycle, coincident with md_busy=1.

## Configuration
- Macro: PIPELINE_SEQUENCER_PERF_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on every rising edge where state≠RUN.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset.
- Undefined: the counter logic is not built and stall_cycles is tied to 16'h0000. The port is always present.

## Test plan
- Reset then idle: with rst_n released and all inputs 0 for 10 cycles, seq_state=0, pc_en=if_id_en=id_ex_en=1, all flushes 0, stall_cycles=0.
- Load-use stall: a 1-cycle haz_stall pulse gives exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then RUN. stall_cycles=1 with the macro, 0 without.
- MULT with MD_CYCLES=8: an md_start pulse gives 8 cycles of md_busy=1 and id_ex_en=0. md_done=1 only in the 8th cycle; RUN follows on the 9th.
- Branch priority: br_taken=md_start=haz_stall=1 in the same cycle gives 2 FLUSH cycles (if_id_flush=id_ex_flush=1, pc_en=1). md_busy stays 0 throughout; then RUN.
- Reset mid-sequence: rst_n asserted in the 4th MD_WAIT cycle makes outputs RUN values asynchronously. No md_done pulse; cnt=0 after release.
- Saturation (macro on): hold md_start high with MD_CYCLES=255 for more than 65535 non-RUN cycles. stall_cycles stops at 16'hFFFF and does not wrap.
